// File: rtl/wb_commit_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | wb_commit_queue: in-order 4-in/4-out writeback queue feeding the regfile,    |
// | optional WB_BYPASS_EN adds two youngest-match lookup ports.  Rev 1.0         |
// +-----------------------------------------------------------------------------+
module wb_commit_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic [3:0]               in_valid,
  input  logic [4*AW-1:0]          in_addr,
  input  logic [4*DW-1:0]          in_data,
  output logic                     in_ready,
  output logic                     we0,
  output logic                     we1,
  output logic                     we2,
  output logic                     we3,
  output logic [AW-1:0]            waddr0,
  output logic [AW-1:0]            waddr1,
  output logic [AW-1:0]            waddr2,
  output logic [AW-1:0]            waddr3,
  output logic [DW-1:0]            wdata0,
  output logic [DW-1:0]            wdata1,
  output logic [DW-1:0]            wdata2,
  output logic [DW-1:0]            wdata3,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
`ifdef WB_BYPASS_EN
  ,
  input  logic [AW-1:0]            lk_addr0,
  input  logic [AW-1:0]            lk_addr1,
  output logic                     lk_hit0,
  output logic                     lk_hit1,
  output logic [DW-1:0]            lk_data0,
  output logic [DW-1:0]            lk_data1
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_READY_MAX = CW'(DEPTH - 4);

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [2:0]    w_n;
  logic [2:0]    w_pop;
  logic [2:0]    w_pop_eff;
  logic [2:0]    w_off [4];
  logic          w_enq;
  logic          w_act [4];
  logic          w_we  [4];
  logic [AW-1:0] w_pa  [4];
  logic [DW-1:0] w_pd  [4];
  logic [AW-1:0] w_oa  [4];
  logic [DW-1:0] w_od  [4];

  assign in_ready = (r_count <= c_READY_MAX);
  assign count    = r_count;
  assign empty    = (r_count == '0);
  assign w_enq    = in_ready & ~rst;

  // Drain size is forced to zero during reset so no partial group escapes.
  always_comb begin
    w_n = 3'd0;
    if (!rst && !stall) begin
      w_n = (r_count >= CW'(4)) ? 3'd4 : 3'(r_count);
    end
  end

  always_comb begin
    w_pop = 3'd0;
    for (int k = 0; k < 4; k++) begin
      w_off[k] = w_pop;
      w_pop    = w_pop + {2'b00, in_valid[k]};
    end
  end

  assign w_pop_eff = w_enq ? w_pop : 3'd0;

  for (genvar k = 0; k < 4; k++) begin : g_port
    logic [PW-1:0] w_idx;
    assign w_idx   = r_head + PW'(k);
    assign w_pa[k] = r_addr[w_idx];
    assign w_pd[k] = r_data[w_idx];
    assign w_act[k] = (3'(k) < w_n);
    assign w_oa[k] = w_act[k] ? w_pa[k] : '0;
    assign w_od[k] = w_act[k] ? w_pd[k] : '0;
  end

  // A port loses its enable to $zero or to any younger port hitting the same register.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_we[k] = w_act[k] && (w_pa[k] != '0);
      for (int j = k + 1; j < 4; j++) begin
        if (w_act[j] && (w_pa[j] == w_pa[k])) begin
          w_we[k] = 1'b0;
        end
      end
    end
  end

  assign we0    = w_we[0];
  assign we1    = w_we[1];
  assign we2    = w_we[2];
  assign we3    = w_we[3];
  assign waddr0 = w_oa[0];
  assign waddr1 = w_oa[1];
  assign waddr2 = w_oa[2];
  assign waddr3 = w_oa[3];
  assign wdata0 = w_od[0];
  assign wdata1 = w_od[1];
  assign wdata2 = w_od[2];
  assign wdata3 = w_od[3];

  always_ff @(posedge clk) begin
    if (w_enq) begin
      for (int k = 0; k < 4; k++) begin
        if (in_valid[k]) begin
          r_addr[r_tail + PW'(w_off[k])] <= in_addr[k*AW +: AW];
          r_data[r_tail + PW'(w_off[k])] <= in_data[k*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_n);
      r_tail  <= r_tail + PW'(w_pop_eff);
      r_count <= r_count + CW'(w_pop_eff) - CW'(w_n);
    end
  end

`ifdef WB_BYPASS_EN
  logic [AW-1:0] w_lk_addr [2];
  logic          w_lk_hit  [2];
  logic [DW-1:0] w_lk_data [2];

  assign w_lk_addr[0] = lk_addr0;
  assign w_lk_addr[1] = lk_addr1;

  // Scanning oldest to youngest lets the youngest match win.
  for (genvar g = 0; g < 2; g++) begin : g_lookup
    always_comb begin
      w_lk_hit[g]  = 1'b0;
      w_lk_data[g] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < r_count) && (w_lk_addr[g] != '0) &&
            (r_addr[r_head + PW'(i)] == w_lk_addr[g])) begin
          w_lk_hit[g]  = 1'b1;
          w_lk_data[g] = r_data[r_head + PW'(i)];
        end
      end
    end
  end

  assign lk_hit0  = w_lk_hit[0];
  assign lk_hit1  = w_lk_hit[1];
  assign lk_data0 = w_lk_data[0];
  assign lk_data1 = w_lk_data[1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_wb_commit_queue: directed + randomized bench with a queue-based model.    |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module tb_wb_commit_queue;
  localparam int DEPTH = 16;
  localparam int AW    = 6;
  localparam int DW    = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            stall = 1'b0;
  logic [3:0]      in_valid = '0;
  logic [4*AW-1:0] in_addr = '0;
  logic [4*DW-1:0] in_data = '0;
  logic            in_ready;
  logic            we0, we1, we2, we3;
  logic [AW-1:0]   waddr0, waddr1, waddr2, waddr3;
  logic [DW-1:0]   wdata0, wdata1, wdata2, wdata3;
  logic [4:0]      count;
  logic            empty;
`ifdef WB_BYPASS_EN
  logic [AW-1:0]   lk_addr0 = '0, lk_addr1 = '0;
  logic            lk_hit0, lk_hit1;
  logic [DW-1:0]   lk_data0, lk_data1;
`endif

  wb_commit_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready),
    .we0(we0), .we1(we1), .we2(we2), .we3(we3),
    .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2), .waddr3(waddr3),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3),
    .count(count), .empty(empty)
`ifdef WB_BYPASS_EN
    , .lk_addr0(lk_addr0), .lk_addr1(lk_addr1), .lk_hit0(lk_hit0), .lk_hit1(lk_hit1),
    .lk_data0(lk_data0), .lk_data1(lk_data1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t q[$];

  int checks = 0;
  int errors = 0;

  logic          a_we [4];
  logic [AW-1:0] a_wa [4];
  logic [DW-1:0] a_wd [4];
  logic          e_we [4];
  logic [AW-1:0] e_wa [4];
  logic [DW-1:0] e_wd [4];
  int            e_count;
  logic          e_ready;

  assign a_we[0] = we0; assign a_we[1] = we1; assign a_we[2] = we2; assign a_we[3] = we3;
  assign a_wa[0] = waddr0; assign a_wa[1] = waddr1; assign a_wa[2] = waddr2; assign a_wa[3] = waddr3;
  assign a_wd[0] = wdata0; assign a_wd[1] = wdata1; assign a_wd[2] = wdata2; assign a_wd[3] = wdata3;

  function automatic logic [4*AW-1:0] pk_a(int a0, int a1, int a2, int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [4*DW-1:0] pk_d(int d0, int d1, int d2, int d3);
    return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  // Expected drain: the oldest min(size,4) entries; an entry is written only
  // if its register is not $zero and it is the last write to that register in the group.
  task automatic calc_exp();
    int n;
    n = (stall || rst) ? 0 : ((q.size() < 4) ? q.size() : 4);
    for (int k = 0; k < 4; k++) begin
      e_we[k] = 1'b0; e_wa[k] = '0; e_wd[k] = '0;
    end
    for (int k = 0; k < n; k++) begin
      bit later;
      later = 0;
      for (int j = k + 1; j < n; j++) if (q[j].a == q[k].a) later = 1;
      e_wa[k] = q[k].a;
      e_wd[k] = q[k].d;
      e_we[k] = (q[k].a != 0) && !later;
    end
    e_count = q.size();
    e_ready = ((DEPTH - q.size()) >= 4);
  endtask

  task automatic lk_expect(input logic [AW-1:0] la, output logic hit, output logic [DW-1:0] dat);
    hit = 1'b0; dat = '0;
    if (la != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a == la) begin hit = 1'b1; dat = q[i].d; break; end
      end
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [4*AW-1:0] a,
                       input logic [4*DW-1:0] d, input logic s);
    @(negedge clk);
    rst = r; in_valid = v; in_addr = a; in_data = d; stall = s;
    #1;
    calc_exp();
  endtask

  // Applies the edge to the model using the inputs currently held, then lets the DUT see it.
  task automatic tick();
    int n;
    bit rdy;
    rdy = ((DEPTH - q.size()) >= 4);
    if (rst) q.delete();
    else begin
      n = stall ? 0 : ((q.size() < 4) ? q.size() : 4);
      repeat (n) void'(q.pop_front());
      if (rdy) for (int k = 0; k < 4; k++)
        if (in_valid[k]) q.push_back({in_addr[k*AW +: AW], in_data[k*DW +: DW]});
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic s);
    drive(1'b0, 4'b0000, '0, '0, s);
  endtask

  task automatic test_reset();
    drive(1'b1, 4'b1111, pk_a(1, 2, 3, 4), pk_d(1, 2, 3, 4), 1'b0);
    tick();
    drive(1'b1, 4'b1111, pk_a(1, 2, 3, 4), pk_d(1, 2, 3, 4), 1'b0);
    checks++; if (we0 !== 1'b0) begin errors++; $display("FAIL rst_we0: got %b want 0", we0); end
    tick();
    idle(1'b0);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", empty); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    checks++; if ({we0, we1, we2, we3} !== 4'b0000) begin errors++; $display("FAIL rst_we: got %b want 0000", {we0, we1, we2, we3}); end
    tick();
  endtask

  task automatic test_full_group();
    drive(1'b0, 4'b1111, pk_a(1, 2, 3, 4), pk_d('hA1, 'hA2, 'hA3, 'hA4), 1'b0);
    tick();
    idle(1'b0);
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL full_count: got %0d want 4", count); end
    checks++; if ({we0, we1, we2, we3} !== 4'b1111) begin errors++; $display("FAIL full_we: got %b want 1111", {we0, we1, we2, we3}); end
    checks++; if ({waddr0, waddr1, waddr2, waddr3} !== {6'd1, 6'd2, 6'd3, 6'd4}) begin errors++; $display("FAIL full_waddr: got %0d %0d %0d %0d want 1 2 3 4", waddr0, waddr1, waddr2, waddr3); end
    checks++; if ({wdata0, wdata1, wdata2, wdata3} !== {32'hA1, 32'hA2, 32'hA3, 32'hA4}) begin errors++; $display("FAIL full_wdata: got %h %h %h %h want a1..a4", wdata0, wdata1, wdata2, wdata3); end
    tick();
    idle(1'b0);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL full_drained: got %0d want 0", count); end
    tick();
  endtask

  task automatic test_sparse();
    drive(1'b0, 4'b1010, pk_a(63, 7, 63, 9), pk_d('h10, 'h17, 'h12, 'h19), 1'b0);
    tick();
    idle(1'b0);
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL sparse_count: got %0d want 2", count); end
    checks++; if ({we0, waddr0, wdata0} !== {1'b1, 6'd7, 32'h17}) begin errors++; $display("FAIL sparse_p0: got we %b addr %0d data %h want 1 7 17", we0, waddr0, wdata0); end
    checks++; if ({we1, waddr1, wdata1} !== {1'b1, 6'd9, 32'h19}) begin errors++; $display("FAIL sparse_p1: got we %b addr %0d data %h want 1 9 19", we1, waddr1, wdata1); end
    checks++; if ({we2, we3, waddr2, wdata3} !== '0) begin errors++; $display("FAIL sparse_idle: got we2 %b we3 %b waddr2 %0d wdata3 %h want zeros", we2, we3, waddr2, wdata3); end
    tick();
  endtask

  task automatic test_collision();
    drive(1'b0, 4'b1111, pk_a(5, 5, 0, 32), pk_d('h50, 'h51, 'h52, 'h53), 1'b0);
    tick();
    idle(1'b0);
    checks++; if ({we0, we1, we2, we3} !== 4'b0101) begin errors++; $display("FAIL coll_we: got %b want 0101", {we0, we1, we2, we3}); end
    checks++; if ({waddr1, wdata1} !== {6'd5, 32'h51}) begin errors++; $display("FAIL coll_p1: got %0d %h want 5 51", waddr1, wdata1); end
    checks++; if ({waddr3, wdata3} !== {6'd32, 32'h53}) begin errors++; $display("FAIL coll_p3: got %0d %h want 32 53", waddr3, wdata3); end
    tick();
    idle(1'b0);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL coll_popped: got %0d want 0", count); end
    tick();
  endtask

  task automatic test_stall_fill();
    drive(1'b0, 4'b0001, pk_a(10, 0, 0, 0), pk_d('h100, 0, 0, 0), 1'b1);
    tick();
    for (int g = 0; g < 3; g++) begin
      drive(1'b0, 4'b1111, pk_a(11 + 4*g, 12 + 4*g, 13 + 4*g, 14 + 4*g), pk_d($urandom, $urandom, $urandom, $urandom), 1'b1);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b want 1", g, in_ready); end
      checks++; if ({we0, we1, we2, we3} !== 4'b0000) begin errors++; $display("FAIL fill_we%0d: got %b want 0000", g, {we0, we1, we2, we3}); end
      tick();
    end
    drive(1'b0, 4'b1111, pk_a(60, 61, 62, 63), pk_d(1, 2, 3, 4), 1'b1);
    checks++; if ({in_ready, count} !== {1'b0, 5'd13}) begin errors++; $display("FAIL fill_full: got ready %b count %0d want 0 13", in_ready, count); end
    tick();
    drive(1'b0, 4'b1111, pk_a(60, 61, 62, 63), pk_d(1, 2, 3, 4), 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) idle(1'b0);
      checks++; if (count !== 5'(e_count)) begin errors++; $display("FAIL drain_count%0d: got %0d want %0d", c, count, e_count); end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ({a_we[k], a_wa[k], a_wd[k]} !== {e_we[k], e_wa[k], e_wd[k]}) begin
          errors++; $display("FAIL drain%0d_p%0d: got %b/%0d/%h want %b/%0d/%h", c, k, a_we[k], a_wa[k], a_wd[k], e_we[k], e_wa[k], e_wd[k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 4'b0000, '0, '0, 1'b0);
    tick();
    for (int g = 0; g < 4; g++) begin
      drive(1'b0, (g == 3) ? 4'b0011 : 4'b1111, pk_a(1, 2, 3, 4), pk_d(g, g, g, g), 1'b1);
      tick();
    end
    for (int c = 0; c < 4; c++) begin idle(1'b0); tick(); end
    drive(1'b0, 4'b1111, pk_a(20, 21, 22, 23), pk_d('hC0, 'hC1, 'hC2, 'hC3), 1'b0);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL wrap_pre: got %0d want 0", count); end
    tick();
    idle(1'b0);
    checks++; if ({wdata0, wdata1, wdata2, wdata3} !== {32'hC0, 32'hC1, 32'hC2, 32'hC3}) begin errors++; $display("FAIL wrap_data: got %h %h %h %h want c0..c3", wdata0, wdata1, wdata2, wdata3); end
    checks++; if ({we0, we1, we2, we3, waddr0, waddr3} !== {4'b1111, 6'd20, 6'd23}) begin errors++; $display("FAIL wrap_addr: got we %b a0 %0d a3 %0d want 1111 20 23", {we0, we1, we2, we3}, waddr0, waddr3); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int g = 0; g < 2; g++) begin
      drive(1'b0, 4'b1111, pk_a(1, 2, 3, 4), pk_d(9, 9, 9, 9), 1'b1);
      tick();
    end
    drive(1'b1, 4'b1111, pk_a(1, 2, 3, 4), pk_d(9, 9, 9, 9), 1'b0);
    checks++; if ({we0, we1, we2, we3} !== 4'b0000) begin errors++; $display("FAIL midrst_we: got %b want 0000", {we0, we1, we2, we3}); end
    tick();
    idle(1'b0);
    checks++; if ({count, empty} !== {5'd0, 1'b1}) begin errors++; $display("FAIL midrst_state: got count %0d empty %b want 0 1", count, empty); end
    tick();
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    drive(1'b0, 4'b0001, pk_a(8, 0, 0, 0), pk_d('h11, 0, 0, 0), 1'b1);
    tick();
    drive(1'b0, 4'b0001, pk_a(8, 0, 0, 0), pk_d('h22, 0, 0, 0), 1'b1);
    tick();
    idle(1'b1);
    lk_addr0 = 6'd8; lk_addr1 = 6'd9; #1;
    checks++; if ({lk_hit0, lk_data0} !== {1'b1, 32'h22}) begin errors++; $display("FAIL lk_hit: got %b %h want 1 22", lk_hit0, lk_data0); end
    checks++; if ({lk_hit1, lk_data1} !== {1'b0, 32'h0}) begin errors++; $display("FAIL lk_miss: got %b %h want 0 0", lk_hit1, lk_data1); end
    lk_addr0 = 6'd0; #1;
    checks++; if ({lk_hit0, lk_data0} !== {1'b0, 32'h0}) begin errors++; $display("FAIL lk_zero: got %b %h want 0 0", lk_hit0, lk_data0); end
    tick();
    idle(1'b0); tick();
  endtask
`endif

  task automatic test_random();
    int stall_run;
    stall_run = 0;
    for (int c = 0; c < 400; c++) begin
      logic [4*AW-1:0] a;
      logic [AW-1:0] ai;
      for (int k = 0; k < 4; k++) begin
        ai = ($urandom_range(0, 7) == 0) ? AW'(32 + $urandom_range(0, 1)) : AW'($urandom_range(0, 5));
        a[k*AW +: AW] = ai;
      end
      if (stall_run == 0 && $urandom_range(0, 15) == 0) stall_run = $urandom_range(1, 6);
      drive(1'b0, 4'($urandom), a, pk_d($urandom, $urandom, $urandom, $urandom),
            (stall_run > 0) || ($urandom_range(0, 5) == 0));
      if (stall_run > 0) stall_run--;
      checks++; if ({count, empty, in_ready} !== {5'(e_count), e_count == 0, e_ready}) begin
        errors++; $display("FAIL rnd%0d_state: got %0d/%b/%b want %0d/%b/%b", c, count, empty, in_ready, e_count, e_count == 0, e_ready);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ({a_we[k], a_wa[k], a_wd[k]} !== {e_we[k], e_wa[k], e_wd[k]}) begin
          errors++; $display("FAIL rnd%0d_p%0d: got %b/%0d/%h want %b/%0d/%h", c, k, a_we[k], a_wa[k], a_wd[k], e_we[k], e_wa[k], e_wd[k]);
        end
      end
`ifdef WB_BYPASS_EN
      begin
        logic eh;
        logic [DW-1:0] ed;
        lk_addr0 = AW'($urandom_range(0, 5)); lk_addr1 = AW'(32 + $urandom_range(0, 1)); #1;
        lk_expect(lk_addr0, eh, ed);
        checks++; if ({lk_hit0, lk_data0} !== {eh, ed}) begin errors++; $display("FAIL rnd%0d_lk0: got %b %h want %b %h", c, lk_hit0, lk_data0, eh, ed); end
        lk_expect(lk_addr1, eh, ed);
        checks++; if ({lk_hit1, lk_data1} !== {eh, ed}) begin errors++; $display("FAIL rnd%0d_lk1: got %b %h want %b %h", c, lk_hit1, lk_data1, eh, ed); end
      end
`endif
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_sparse();
    test_collision();
    test_stall_fill();
    test_wrap();
    test_reset_mid();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
